div_map_gen: RTL and testbench

- Equalisation-map generator; sits directly upstream of the image mapping controller.
- After the CDF stage signals completion, reads 256 cumulative counts from scratch memory words 0..63 and computes map[i] = ((cdf[i] - cdf_min) * 255) / (total - cdf_min).
- Writes the 256 8-bit map values to scratch words 128..191, then pulses div_sc_mem_wt_done to start the mapping stage.

---
 rtl/div_map_gen.sv | 219 +++++++++++++++++++++
 tb/tb_div_map_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_map_gen.sv
// Equalisation-map generator: scans 64 CDF words, then writes 64 map words at 128+k and pulses done.
// Start->done is 256 + sum(3 + entries + 1 per word) + 1 cycles, with no backpressure. Define DIV_ROUND_EN for round-to-nearest.
module div_map_gen #(
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cdf_sc_mem_wt_done,
  input  logic [127:0] sc_mem_rd_data,
  output logic [15:0]  div_sc_mem_rd_addr,
  output logic [15:0]  div_sc_mem_wt_addr,
  output logic [127:0] div_sc_mem_wt_data,
  output logic         div_sc_mem_wt_en,
  output logic         div_sc_mem_wt_done,
  output logic         div_InProgress
);

  localparam int NW = CNT_W + 8;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN_RD, S_SCAN_WAIT, S_SCAN_CHK, S_CALC_RD, S_CALC_WAIT,
    S_DIV_LOAD, S_DIV_RUN, S_DIV_NEXT, S_WRITE, S_COMPLETE
  } state_t;

  state_t           state_q;
  logic [WW-1:0]    wait_q;
  logic [15:0]      rd_addr_q;
  logic [15:0]      wt_addr_q;
  logic [127:0]     wt_data_q;
  logic [127:0]     word_q;
  logic [127:0]     out_q;
  logic             wt_en_q;
  logic             done_q;
  logic             busy_q;
  logic             min_found_q;
  logic             sat_q;
  logic [CNT_W-1:0] cdf_min_q;
  logic [CNT_W-1:0] total_q;
  logic [1:0]       ent_q;
  logic [2:0]       bit_q;
  logic [NW-1:0]    rem_q;
  logic [7:0]       quo_q;

  logic [CNT_W-1:0] cur_cdf_d;
  logic [CNT_W-1:0] diff_d;
  logic [CNT_W-1:0] den_d;
  logic [CNT_W-1:0] scan_min_d;
  logic [NW-1:0]    num_d;
  logic [NW-1:0]    trial_d;
  logic             skip_d;
  logic             sat_d;
  logic             ge_d;
  logic             scan_hit_d;
  logic [7:0]       res_d;

  // Only the low CNT_W bits of each field carry count information.
  logic unused_rd_bits;
  assign unused_rd_bits = ^sc_mem_rd_data;

  always_comb begin
    cur_cdf_d = '0;
    case (ent_q)
      2'd0:    cur_cdf_d = word_q[96 +: CNT_W];
      2'd1:    cur_cdf_d = word_q[64 +: CNT_W];
      2'd2:    cur_cdf_d = word_q[32 +: CNT_W];
      default: cur_cdf_d = word_q[0 +: CNT_W];
    endcase
    den_d  = total_q - cdf_min_q;
    diff_d = cur_cdf_d - cdf_min_q;
    skip_d = (cur_cdf_d < cdf_min_q) || (den_d == '0);
`ifdef DIV_ROUND_EN
    num_d = {diff_d, 8'd0} - {8'd0, diff_d} + {8'd0, (den_d >> 1)};
    sat_d = (num_d >= {den_d, 8'd0});
`else
    num_d = {diff_d, 8'd0} - {8'd0, diff_d};
    sat_d = 1'b0;
`endif
    trial_d = {8'd0, den_d} << bit_q;
    ge_d    = (rem_q >= trial_d);
    res_d   = sat_q ? 8'hFF : quo_q;

    // First nonzero field in index order within the word being scanned.
    scan_hit_d = 1'b0;
    scan_min_d = '0;
    for (int e = 0; e < 4; e++) begin
      if (!scan_hit_d && (sc_mem_rd_data[96 - 32*e +: CNT_W] != '0)) begin
        scan_hit_d = 1'b1;
        scan_min_d = sc_mem_rd_data[96 - 32*e +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      rd_addr_q   <= '0;
      wt_addr_q   <= '0;
      wt_data_q   <= '0;
      word_q      <= '0;
      out_q       <= '0;
      wt_en_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      min_found_q <= 1'b0;
      sat_q       <= 1'b0;
      cdf_min_q   <= '0;
      total_q     <= '0;
      ent_q       <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
    end else begin
      wt_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cdf_sc_mem_wt_done) begin
            busy_q      <= 1'b1;
            rd_addr_q   <= '0;
            cdf_min_q   <= '0;
            min_found_q <= 1'b0;
            state_q     <= S_SCAN_RD;
          end
        end
        S_SCAN_RD: begin
          wait_q  <= WW'(RD_LAT - 1);
          state_q <= S_SCAN_WAIT;
        end
        S_SCAN_WAIT: begin
          if (wait_q == '0) state_q <= S_SCAN_CHK;
          else              wait_q  <= wait_q - WW'(1);
        end
        S_SCAN_CHK: begin
          if (!min_found_q && scan_hit_d) begin
            cdf_min_q   <= scan_min_d;
            min_found_q <= 1'b1;
          end
          if (rd_addr_q[5:0] == 6'd63) begin
            total_q   <= sc_mem_rd_data[0 +: CNT_W];
            rd_addr_q <= '0;
            state_q   <= S_CALC_RD;
          end else begin
            rd_addr_q <= rd_addr_q + 16'd1;
            state_q   <= S_SCAN_RD;
          end
        end
        S_CALC_RD: begin
          wait_q  <= WW'(RD_LAT - 1);
          state_q <= S_CALC_WAIT;
        end
        S_CALC_WAIT: begin
          if (wait_q == '0) begin
            word_q  <= sc_mem_rd_data;
            ent_q   <= '0;
            state_q <= S_DIV_LOAD;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        S_DIV_LOAD: begin
          quo_q <= '0;
          rem_q <= num_d;
          bit_q <= 3'd7;
          if (skip_d) begin
            sat_q   <= 1'b0;
            state_q <= S_DIV_NEXT;
          end else begin
            sat_q   <= sat_d;
            state_q <= S_DIV_RUN;
          end
        end
        S_DIV_RUN: begin
          // Restoring divide: quotient bits shift in MSB first.
          quo_q <= {quo_q[6:0], ge_d};
          if (ge_d) rem_q <= rem_q - trial_d;
          if (bit_q == 3'd0) state_q <= S_DIV_NEXT;
          else               bit_q   <= bit_q - 3'd1;
        end
        S_DIV_NEXT: begin
          out_q <= {out_q[95:0], 24'd0, res_d};
          if (ent_q == 2'd3) begin
            state_q <= S_WRITE;
          end else begin
            ent_q   <= ent_q + 2'd1;
            state_q <= S_DIV_LOAD;
          end
        end
        S_WRITE: begin
          wt_en_q   <= 1'b1;
          wt_addr_q <= 16'd128 + rd_addr_q;
          wt_data_q <= out_q;
          if (rd_addr_q[5:0] == 6'd63) begin
            state_q <= S_COMPLETE;
          end else begin
            rd_addr_q <= rd_addr_q + 16'd1;
            state_q   <= S_CALC_RD;
          end
        end
        S_COMPLETE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_sc_mem_rd_addr = rd_addr_q;
  assign div_sc_mem_wt_addr = wt_addr_q;
  assign div_sc_mem_wt_data = wt_data_q;
  assign div_sc_mem_wt_en   = wt_en_q;
  assign div_sc_mem_wt_done = done_q;
  assign div_InProgress     = busy_q;

endmodule

// File: tb/tb_div_map_gen.sv
// Directed/randomised bench for div_map_gen with a scratch-memory model and an arithmetic reference map.
module tb_div_map_gen;
  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] rd_data;
  logic [15:0]  rd_addr, wt_addr;
  logic [127:0] wt_data;
  logic         wt_en, done, inprog;

  always #5 clk = ~clk;

  div_map_gen #(.CNT_W(16), .RD_LAT(RD_LAT)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .cdf_sc_mem_wt_done (start),
    .sc_mem_rd_data     (rd_data),
    .div_sc_mem_rd_addr (rd_addr),
    .div_sc_mem_wt_addr (wt_addr),
    .div_sc_mem_wt_data (wt_data),
    .div_sc_mem_wt_en   (wt_en),
    .div_sc_mem_wt_done (done),
    .div_InProgress     (inprog)
  );

  logic [127:0] mem  [0:63];
  logic [127:0] pipe [0:RD_LAT-1];
  logic [127:0] wmem [0:63];
  int           wtag [0:63];
  int           run_id;
  int           wr_cnt = 0, done_cnt = 0, overlap_cnt = 0, bad_addr_cnt = 0;
  int           checks = 0, errors = 0;
  int unsigned  cdf     [256];
  int unsigned  exp_map [256];
  int           exp_lat;

  assign rd_data = pipe[RD_LAT-1];

  always @(posedge clk) begin
    pipe[0] <= (rd_addr < 16'd64) ? mem[rd_addr[5:0]] : 128'd0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (wt_en) begin
      wr_cnt++;
      if (wt_addr < 16'd128 || wt_addr > 16'd191) bad_addr_cnt++;
      else begin
        wmem[wt_addr[5:0]] <= wt_data;
        wtag[wt_addr[5:0]] <= run_id;
      end
    end
    if (done) done_cnt++;
    if (done && wt_en) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 uniform, 1 two-level, 2 single-level, 3 small counts, 4 random, 5 all-zero
  task automatic set_pattern(input int kind);
    int unsigned acc;
    int z;
    acc = 0;
    z = $urandom_range(0, 40);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: cdf[i] = 4 * (i + 1);
        1: cdf[i] = (i < 10) ? 0 : ((i < 200) ? 512 : 1024);
        2: cdf[i] = (i < 100) ? 0 : 1024;
        3: cdf[i] = (i == 0) ? 1 : 2;
        4: begin
          if (i >= z) acc += $urandom_range(0, 200);
          cdf[i] = acc | ($urandom_range(0, 65535) << 16);
        end
        default: cdf[i] = 0;
      endcase
    end
    for (int k = 0; k < 64; k++) mem[k] = {cdf[4*k], cdf[4*k+1], cdf[4*k+2], cdf[4*k+3]};
  endtask

  // Reference: map from the equalisation formula; latency from the per-phase cycle budget.
  task automatic build_model();
    longint unsigned c, cmin, total, den, q;
    bit found;
    cmin = 0;
    found = 0;
    for (int i = 0; i < 256; i++) begin
      c = cdf[i] & 32'hFFFF;
      if (!found && c != 0) begin cmin = c; found = 1; end
    end
    total = cdf[255] & 32'hFFFF;
    den = (total - cmin) & 64'hFFFF;
    exp_lat = 256 + 64 * 4 + 1;
    for (int i = 0; i < 256; i++) begin
      c = cdf[i] & 32'hFFFF;
      if (c < cmin || den == 0) begin
        exp_map[i] = 0;
        exp_lat += 2;
      end else begin
`ifdef DIV_ROUND_EN
        q = ((c - cmin) * 255 + den / 2) / den;
        if (q > 255) q = 255;
`else
        q = ((c - cmin) * 255) / den;
`endif
        exp_map[i] = 32'(q);
        exp_lat += 10;
      end
    end
  endtask

  function automatic logic [127:0] exp_word(input int k);
    return {exp_map[4*k], exp_map[4*k+1], exp_map[4*k+2], exp_map[4*k+3]};
  endfunction

  task automatic do_run(input string name, input int inject_at);
    int n, w0, d0, o0, b0, fresh;
    bit got;
    run_id++;
    build_model();
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt; b0 = bad_addr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 4000) begin
      @(posedge clk); n++; #1;
      start = (n == inject_at);
      if (n == 10) check({name, ":busy"}, inprog, 1'b1);
      if (done) got = 1;
    end
    start = 1'b0;
    check({name, ":done_seen"}, got, 1'b1);
    check({name, ":latency"}, n, exp_lat);
    repeat (6) @(posedge clk);
    #1;
    check({name, ":wr_count"}, wr_cnt - w0, 64);
    check({name, ":done_count"}, done_cnt - d0, 1);
    check({name, ":en_done_overlap"}, overlap_cnt - o0, 0);
    check({name, ":bad_wt_addr"}, bad_addr_cnt - b0, 0);
    check({name, ":idle_after"}, inprog, 1'b0);
    fresh = 0;
    for (int k = 0; k < 64; k++) begin
      if (wtag[k] == run_id) fresh++;
      check($sformatf("%s:word%0d", name, 128 + k), wmem[k], exp_word(k));
    end
    check({name, ":words_fresh"}, fresh, 64);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":rd_addr"}, rd_addr, 16'd0);
    check({tag, ":wt_addr"}, wt_addr, 16'd0);
    check({tag, ":wt_data"}, wt_data, 128'd0);
    check({tag, ":wt_en"}, wt_en, 1'b0);
    check({tag, ":done"}, done, 1'b0);
    check({tag, ":inprog"}, inprog, 1'b0);
  endtask

  initial begin
    int n, w0, d0;
    logic [127:0] word_lo, word_hi;
    run_id = 0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      mem[k] = '0;
      pipe[k % RD_LAT] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    set_pattern(0);
    do_run("uniform", 0);
    word_lo = {32'd0, 32'd1, 32'd2, 32'd3};
    word_hi = {32'd252, 32'd253, 32'd254, 32'd255};
    check("uniform:word128_const", wmem[0], word_lo);
    check("uniform:word191_const", wmem[63], word_hi);
    check("uniform:latency_const", exp_lat, 256 + 64 * 44 + 1);

    set_pattern(1);
    do_run("two_level", 0);
    set_pattern(2);
    do_run("single_level", 0);
    set_pattern(5);
    do_run("all_zero", 0);
    set_pattern(3);
    do_run("small_counts", 0);

    set_pattern(0);
    do_run("busy_start", 500);

    // Abort mid-divide of word 20, then restart from scratch.
    set_pattern(0);
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((wr_cnt - w0) < 20 && n < 4000) begin
      @(posedge clk); n++; #1;
    end
    check("abort:reached_word20", wr_cnt - w0, 20);
    repeat (5) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort_now");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("abort_hold");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort:no_done", done_cnt - d0, 0);
    check("abort:idle", inprog, 1'b0);
    do_run("after_abort", 0);

    for (int r = 0; r < 2; r++) begin
      set_pattern(4);
      do_run($sformatf("random%0d", r), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
